// File: rtl/cfs_algn_pkg.sv
// Shared aligner definitions: RX controller state encoding and the offset/size legality rule.
package cfs_algn_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_PUSH = 2'd1,
    RX_RESP = 2'd2
  } rx_state_t;

  // A transfer is legal when it is non-empty, fits in the word and is aligned to its own size
  function automatic logic algn_is_legal(input int unsigned offset,
                                         input int unsigned size,
                                         input int unsigned nb);
    if (size == 0) return 1'b0;
    if (offset + size > nb) return 1'b0;
    return ((nb + offset) % size) == 0;
  endfunction

endpackage

// File: rtl/cfs_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module cfs_sat_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

  assign at_max = (cnt == CNT_MAX);

endmodule

// File: rtl/cfs_rx_ctrl.sv
// Aligner RX front-end: captures MD RX transfers, pushes legal ones into the RX FIFO and
// answers illegal ones with an error while counting them as drops.
module cfs_rx_ctrl
  import cfs_algn_pkg::*;
#(
  parameter  int unsigned ALGN_DATA_WIDTH       = 32,
  parameter  int unsigned STATUS_CNT_DROP_WIDTH = 8,
  localparam int unsigned DW = ALGN_DATA_WIDTH,
  localparam int unsigned NB = DW / 8,
  localparam int unsigned OW = (DW <= 8) ? 1 : $clog2(NB),
  localparam int unsigned SW = $clog2(NB) + 1,
  localparam int unsigned CW = STATUS_CNT_DROP_WIDTH,
  localparam int unsigned PW = DW + OW + SW
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          md_rx_valid,
  input  logic [DW-1:0] md_rx_data,
  input  logic [OW-1:0] md_rx_offset,
  input  logic [SW-1:0] md_rx_size,
  output logic          md_rx_ready,
  output logic          md_rx_err,
  output logic          push_valid,
  output logic [PW-1:0] push_data,
  input  logic          push_ready,
  input  logic          ctrl_clr,
  output logic [CW-1:0] status_cnt_drop,
  output logic          max_drop
);

  rx_state_t     state_q;
  rx_state_t     state_d;
  logic [DW-1:0] data_q;
  logic [OW-1:0] offset_q;
  logic [SW-1:0] size_q;
  logic          cap_en;
  logic          drop_inc;
  logic          legal_c;
  logic          ready_d;
  logic          err_d;

  // Legality is judged on the values being captured so the decision lands on the capture edge
  assign legal_c = algn_is_legal(32'(md_rx_offset), 32'(md_rx_size), NB);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= RX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_en   = 1'b0;
    drop_inc = 1'b0;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (md_rx_valid) begin
          cap_en = 1'b1;
          if (legal_c) begin
            state_d = RX_PUSH;
          end else begin
            state_d  = RX_RESP;
            drop_inc = 1'b1;
            ready_d  = 1'b1;
            err_d    = 1'b1;
          end
        end
      end
      RX_PUSH: begin
        if (push_ready) begin
          state_d = RX_RESP;
          ready_d = 1'b1;
        end
      end
      RX_RESP: begin
        state_d = RX_IDLE;
      end
      default: begin
        state_d = RX_IDLE;
      end
    endcase
  end

  // Capture registers hold the transfer stable for the whole push/backpressure window
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      data_q   <= '0;
      offset_q <= '0;
      size_q   <= '0;
    end else if (cap_en) begin
      data_q   <= md_rx_data;
      offset_q <= md_rx_offset;
      size_q   <= md_rx_size;
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      md_rx_ready <= 1'b0;
      md_rx_err   <= 1'b0;
    end else begin
      md_rx_ready <= ready_d;
      md_rx_err   <= err_d;
    end
  end

  assign push_valid = (state_q == RX_PUSH);
  assign push_data  = {size_q, offset_q, data_q};

  cfs_sat_counter #(
    .WIDTH(CW)
  ) u_drop_cnt (
    .pclk   (pclk),
    .presetn(presetn),
    .inc    (drop_inc),
    .clr    (ctrl_clr),
    .cnt    (status_cnt_drop),
    .at_max (max_drop)
  );

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Scoreboard bench for cfs_rx_ctrl: driver queues expected pushes/responses, monitor checks them.
module tb_cfs_rx_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 2;
  localparam int unsigned SW = 3;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = DW + OW + SW;
  localparam int CNT_SAT = 255;

  typedef struct packed {
    logic          err;
    logic [CW-1:0] cnt;
  } resp_t;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          md_rx_valid;
  logic [DW-1:0] md_rx_data;
  logic [OW-1:0] md_rx_offset;
  logic [SW-1:0] md_rx_size;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [PW-1:0] push_data;
  logic          push_ready;
  logic          ctrl_clr;
  logic [CW-1:0] status_cnt_drop;
  logic          max_drop;

  logic [PW-1:0] push_q[$];
  resp_t         resp_q[$];
  resp_t         mon_r;
  int            vectors = 0;
  int            errors  = 0;
  int            model_cnt = 0;

  always #5 pclk = ~pclk;

  cfs_rx_ctrl #(
    .ALGN_DATA_WIDTH      (DW),
    .STATUS_CNT_DROP_WIDTH(CW)
  ) dut (
    .pclk           (pclk),
    .presetn        (presetn),
    .md_rx_valid    (md_rx_valid),
    .md_rx_data     (md_rx_data),
    .md_rx_offset   (md_rx_offset),
    .md_rx_size     (md_rx_size),
    .md_rx_ready    (md_rx_ready),
    .md_rx_err      (md_rx_err),
    .push_valid     (push_valid),
    .push_data      (push_data),
    .push_ready     (push_ready),
    .ctrl_clr       (ctrl_clr),
    .status_cnt_drop(status_cnt_drop),
    .max_drop       (max_drop)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Legal = an aligned access of 1, 2 or 4 bytes fully inside the 4-byte word
  function automatic bit ref_legal(input int off, input int size);
    case (size)
      1:       return 1'b1;
      2:       return (off == 0) || (off == 2);
      4:       return off == 0;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge pclk) begin
    if (presetn) begin
      if (push_valid) begin
        check("push_expected", 64'(push_q.size() != 0), 64'd1);
        if (push_q.size() != 0) begin
          check("push_data", 64'(push_data), 64'(push_q[0]));
          if (push_ready) void'(push_q.pop_front());
        end
      end
      if (md_rx_ready) begin
        check("ready_expected", 64'(resp_q.size() != 0), 64'd1);
        if (resp_q.size() != 0) begin
          mon_r = resp_q.pop_front();
          check("rx_err", 64'(md_rx_err), 64'(mon_r.err));
          check("cnt_drop", 64'(status_cnt_drop), 64'(mon_r.cnt));
          check("max_drop", 64'(max_drop), 64'(mon_r.cnt == CW'(CNT_SAT)));
        end
      end
    end
  end

  task automatic do_xfer(input int off, input int size, input logic [DW-1:0] data,
                         input int stall, input bit clr_same);
    bit    legal;
    int    n;
    resp_t r;
    legal = ref_legal(off, size);
    if (clr_same) model_cnt = 0;
    else if (!legal && model_cnt < CNT_SAT) model_cnt++;
    if (legal) push_q.push_back({SW'(size), OW'(off), data});
    r.err = !legal;
    r.cnt = CW'(model_cnt);
    resp_q.push_back(r);
    md_rx_valid  = 1'b1;
    md_rx_offset = OW'(off);
    md_rx_size   = SW'(size);
    md_rx_data   = data;
    ctrl_clr     = clr_same;
    push_ready   = 1'b0;
    n = 0;
    while (n <= 40) begin
      @(posedge pclk);
      #1;
      n++;
      if (n == 1) begin
        // Inputs change after capture; the DUT must keep the captured entry
        ctrl_clr     = 1'b0;
        md_rx_data   = $urandom;
        md_rx_offset = OW'($urandom);
        md_rx_size   = SW'($urandom);
      end
      push_ready = (n > stall);
      if (md_rx_ready) break;
    end
    check("latency", 64'(n), legal ? 64'(2 + stall) : 64'd1);
    md_rx_valid = 1'b0;
    push_ready  = 1'($urandom);
    @(posedge pclk);
    #1;
  endtask

  task automatic do_clear();
    ctrl_clr = 1'b1;
    @(posedge pclk);
    #1;
    ctrl_clr  = 1'b0;
    model_cnt = 0;
    check("clr_cnt", 64'(status_cnt_drop), 64'd0);
    check("clr_max", 64'(max_drop), 64'd0);
  endtask

  initial begin
    presetn      = 1'b0;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b0;
    ctrl_clr     = 1'b0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_ready", 64'(md_rx_ready), 64'd0);
    check("rst_err", 64'(md_rx_err), 64'd0);
    check("rst_push_valid", 64'(push_valid), 64'd0);
    check("rst_push_data", 64'(push_data), 64'd0);
    check("rst_cnt", 64'(status_cnt_drop), 64'd0);
    check("rst_max", 64'(max_drop), 64'd0);
    presetn = 1'b1;
    @(posedge pclk);
    #1;

    do_xfer(0, 4, 32'hDEADBEEF, 0, 1'b0);
    check("t1_cnt", 64'(status_cnt_drop), 64'd0);

    do_xfer(1, 2, $urandom, 0, 1'b0);
    do_xfer(3, 2, $urandom, 0, 1'b0);
    do_xfer(0, 0, $urandom, 0, 1'b0);
    check("t2_cnt", 64'(status_cnt_drop), 64'd3);
    do_xfer(2, 2, $urandom, 0, 1'b0);

    do_xfer(1, 1, 32'hA5A5_0F0F, 5, 1'b0);

    do_clear();
    for (int i = 0; i < 260; i++) do_xfer(1, 2, $urandom, 0, 1'b0);
    check("t4_cnt", 64'(status_cnt_drop), 64'd255);
    check("t4_max", 64'(max_drop), 64'd1);
    do_clear();

    do_xfer(0, 3, $urandom, 0, 1'b0);
    do_xfer(2, 4, $urandom, 0, 1'b0);
    do_xfer(3, 2, $urandom, 0, 1'b1);
    check("t5_cnt", 64'(status_cnt_drop), 64'd0);

    // Reset while a legal transfer is stalled in the push phase
    push_q.push_back({SW'(4), OW'(0), 32'h1234_5678});
    md_rx_valid  = 1'b1;
    md_rx_offset = OW'(0);
    md_rx_size   = SW'(4);
    md_rx_data   = 32'h1234_5678;
    push_ready   = 1'b0;
    repeat (2) begin
      @(posedge pclk);
      #1;
    end
    check("t6_in_push", 64'(push_valid), 64'd1);
    presetn     = 1'b0;
    md_rx_valid = 1'b0;
    #1;
    check("t6_push_valid", 64'(push_valid), 64'd0);
    check("t6_push_data", 64'(push_data), 64'd0);
    check("t6_ready", 64'(md_rx_ready), 64'd0);
    check("t6_cnt", 64'(status_cnt_drop), 64'd0);
    push_q.delete();
    resp_q.delete();
    model_cnt = 0;
    @(posedge pclk);
    #1;
    presetn = 1'b1;
    repeat (3) @(posedge pclk);
    #1;
    do_xfer(0, 4, 32'hCAFE_F00D, 1, 1'b0);

    for (int i = 0; i < 150; i++) begin
      do_xfer(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), $urandom,
              int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0));
    end

    repeat (4) @(posedge pclk);
    #1;
    check("queues_drained", 64'(push_q.size() + resp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
